// File: rtl/dmem_ctrl.sv
// dmem_ctrl: data-memory controller behind the EX/MEM register.
// Owns a word-organised synchronous RAM and serves byte/half/word loads and
// stores selected by func3. Full-word stores complete in the acceptance
// cycle. Sub-word stores use a read-modify-write sequence. Loads return
// sign- or zero-extended data with a one-cycle rd_valid pulse.
//
// Ports:
//   clk, reset        clock, asynchronous active-low reset
//   req_valid/ready   request handshake (ready only in IDLE)
//   MemRead/MemWrite  load / store request
//   addr              byte address
//   wr_data           store data, right-aligned
//   func3             access size and sign
//   rd_valid/rd_data  load result pulse / held load data
//   err               one-cycle pulse after an illegal request is accepted
//   busy              pipeline stall (inverse of req_ready)
//   load_cnt, store_cnt, stall_cnt   saturating perf counters (only when
//                                    DMEM_PERF_EN is defined)
module dmem_ctrl #(
    parameter int unsigned DM_ADDRESS = 9,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned DEPTH_W    = 128
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  MemRead,
    input  logic                  MemWrite,
    input  logic [DM_ADDRESS-1:0] addr,
    input  logic [DATA_W-1:0]     wr_data,
    input  logic [2:0]            func3,
    output logic                  rd_valid,
    output logic [DATA_W-1:0]     rd_data,
    output logic                  err,
    output logic                  busy
`ifdef DMEM_PERF_EN
    ,
    output logic [15:0]           load_cnt,
    output logic [15:0]           store_cnt,
    output logic [15:0]           stall_cnt
`endif
);

    localparam int unsigned IDX_W = DM_ADDRESS - 2;

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_RMW_RD,
        S_RMW_WR
    } state_e;

    state_e             state_q, state_d;
    logic               ready_q, busy_q;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [1:0]         lane_q, lane_d;
    logic [2:0]         f3_q, f3_d;
    logic [15:0]        wdata_q, wdata_d;
    logic [DATA_W-1:0]  rd_data_q, rd_data_d;
    logic               rd_valid_q, rd_valid_d;
    logic               err_q, err_d;

    logic [DATA_W-1:0]  mem_q [DEPTH_W];
    logic [DATA_W-1:0]  ram_q;

    logic               accept_c;
    logic               illegal_c;
    logic [IDX_W-1:0]   idx_in_c;
    logic [IDX_W-1:0]   ram_raddr_c;
    logic               mem_we_c;
    logic [IDX_W-1:0]   mem_waddr_c;
    logic [DATA_W-1:0]  mem_wdata_c;
    logic [7:0]         byte_c;
    logic [15:0]        half_c;
    logic [DATA_W-1:0]  merged_c;
    logic [DATA_W-1:0]  ext_c;

    assign accept_c = req_valid && ready_q;
    assign idx_in_c = addr[DM_ADDRESS-1:2];

    // Legality of the presented request; no-ops (neither read nor write) are legal
    always_comb begin
        illegal_c = 1'b0;
        if (MemRead && MemWrite) begin
            illegal_c = 1'b1;
        end else if (MemRead) begin
            if (func3 == 3'b011 || func3 == 3'b110 || func3 == 3'b111) illegal_c = 1'b1;
        end else if (MemWrite) begin
            if (func3 != 3'b000 && func3 != 3'b001 && func3 != 3'b010) illegal_c = 1'b1;
        end
        if ((MemRead || MemWrite) && func3[1:0] == 2'b01 && addr[0]) illegal_c = 1'b1;
        if ((MemRead || MemWrite) && func3[1:0] == 2'b10 && addr[1:0] != 2'b00) illegal_c = 1'b1;
    end

    // Lane extraction from the RAM read register
    assign byte_c = ram_q[{lane_q, 3'b000} +: 8];
    assign half_c = ram_q[{lane_q[1], 4'b0000} +: 16];

    // Load extension
    always_comb begin
        case (f3_q)
            3'b000:  ext_c = {{(DATA_W-8){byte_c[7]}}, byte_c};
            3'b001:  ext_c = {{(DATA_W-16){half_c[15]}}, half_c};
            3'b100:  ext_c = {{(DATA_W-8){1'b0}}, byte_c};
            3'b101:  ext_c = {{(DATA_W-16){1'b0}}, half_c};
            default: ext_c = ram_q;
        endcase
    end

    // Sub-word merge for the RMW write (f3_q[0]=0 is SB, 1 is SH)
    always_comb begin
        merged_c = ram_q;
        if (f3_q[0]) merged_c[{lane_q[1], 4'b0000} +: 16] = wdata_q;
        else         merged_c[{lane_q, 3'b000} +: 8]     = wdata_q[7:0];
    end

    // Next-state and datapath control
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        lane_d      = lane_q;
        f3_d        = f3_q;
        wdata_d     = wdata_q;
        rd_data_d   = rd_data_q;
        rd_valid_d  = 1'b0;
        err_d       = 1'b0;
        mem_we_c    = 1'b0;
        mem_waddr_c = idx_q;
        mem_wdata_c = merged_c;
        ram_raddr_c = idx_q;
        case (state_q)
            S_IDLE: begin
                // Loads read at the acceptance edge straight from the request address
                ram_raddr_c = idx_in_c;
                if (accept_c) begin
                    idx_d   = idx_in_c;
                    lane_d  = addr[1:0];
                    f3_d    = func3;
                    wdata_d = wr_data[15:0];
                    if (illegal_c) begin
                        err_d = 1'b1;
                    end else if (MemWrite) begin
                        if (func3 == 3'b010) begin
                            mem_we_c    = 1'b1;
                            mem_waddr_c = idx_in_c;
                            mem_wdata_c = wr_data;
                        end else begin
                            state_d = S_RMW_RD;
                        end
                    end else if (MemRead) begin
                        state_d = S_LOAD;
                    end
                end
            end
            S_LOAD: begin
                rd_data_d  = ext_c;
                rd_valid_d = 1'b1;
                state_d    = S_IDLE;
            end
            S_RMW_RD: begin
                state_d = S_RMW_WR;
            end
            S_RMW_WR: begin
                mem_we_c = 1'b1;
                state_d  = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Control and output registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            ready_q    <= 1'b1;
            busy_q     <= 1'b0;
            idx_q      <= '0;
            lane_q     <= '0;
            f3_q       <= '0;
            wdata_q    <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            ready_q    <= (state_d == S_IDLE);
            busy_q     <= (state_d != S_IDLE);
            idx_q      <= idx_d;
            lane_q     <= lane_d;
            f3_q       <= f3_d;
            wdata_q    <= wdata_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
            err_q      <= err_d;
        end
    end

    // RAM array; contents survive reset, writes are blocked while reset is held
    always_ff @(posedge clk) begin
        if (reset && mem_we_c) mem_q[mem_waddr_c] <= mem_wdata_c;
        ram_q <= mem_q[ram_raddr_c];
    end

    assign req_ready = ready_q;
    assign busy      = busy_q;
    assign rd_valid  = rd_valid_q;
    assign rd_data   = rd_data_q;
    assign err       = err_q;

`ifdef DMEM_PERF_EN
    logic [15:0] load_cnt_q, store_cnt_q, stall_cnt_q;
    logic        legal_acc_c;

    assign legal_acc_c = accept_c && !illegal_c;

    // Saturating performance counters
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            load_cnt_q  <= '0;
            store_cnt_q <= '0;
            stall_cnt_q <= '0;
        end else begin
            if (legal_acc_c && MemRead && load_cnt_q != 16'hFFFF)
                load_cnt_q <= load_cnt_q + 16'd1;
            if (legal_acc_c && MemWrite && store_cnt_q != 16'hFFFF)
                store_cnt_q <= store_cnt_q + 16'd1;
            if (busy_q && stall_cnt_q != 16'hFFFF)
                stall_cnt_q <= stall_cnt_q + 16'd1;
        end
    end

    assign load_cnt  = load_cnt_q;
    assign store_cnt = store_cnt_q;
    assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_dmem_ctrl.sv
// Scoreboard testbench for dmem_ctrl: stimulus pushes expected load/err
// responses into a queue, a monitor pops and compares them as the DUT
// presents rd_valid or err.
module tb_dmem_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        MemRead, MemWrite;
    logic [8:0]  addr;
    logic [31:0] wr_data;
    logic [2:0]  func3;
    logic        rd_valid;
    logic [31:0] rd_data;
    logic        err;
    logic        busy;
`ifdef DMEM_PERF_EN
    logic [15:0] load_cnt, store_cnt, stall_cnt;
`endif

    int checks = 0;
    int errors = 0;

    typedef struct {
        bit          is_err;
        logic [31:0] data;
    } exp_t;

    exp_t exp_q[$];

    dmem_ctrl dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .MemRead   (MemRead),
        .MemWrite  (MemWrite),
        .addr      (addr),
        .wr_data   (wr_data),
        .func3     (func3),
        .rd_valid  (rd_valid),
        .rd_data   (rd_data),
        .err       (err),
        .busy      (busy)
`ifdef DMEM_PERF_EN
        ,
        .load_cnt  (load_cnt),
        .store_cnt (store_cnt),
        .stall_cnt (stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every rd_valid/err pulse must match the oldest expected response
    initial begin
        forever begin
            @(negedge clk);
            if (reset && (rd_valid || err)) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_output: rd_valid=%0b err=%0b rd_data=0x%08h with nothing expected",
                             rd_valid, err, rd_data);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("resp_is_err", 32'(err), 32'(e.is_err));
                    chk("resp_rd_valid", 32'(rd_valid), 32'(!e.is_err));
                    if (!e.is_err) chk("rd_data", rd_data, e.data);
                end
            end
        end
    end

    // Issue one request; returns the number of busy cycles following acceptance
    task automatic issue(input logic mr, input logic mw, input logic [8:0] a,
                         input logic [31:0] wd, input logic [2:0] f3, output int stall);
        int w;
        w = 0;
        while (!req_ready && w < 20) begin
            @(posedge clk);
            #1;
            w++;
        end
        if (!req_ready) chk("ready_timeout", 32'(req_ready), 32'd1);
        req_valid = 1'b1;
        MemRead   = mr;
        MemWrite  = mw;
        addr      = a;
        wr_data   = wd;
        func3     = f3;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        MemRead   = 1'b0;
        MemWrite  = 1'b0;
        stall = 0;
        while (busy && stall < 8) begin
            stall++;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_store(input logic [8:0] a, input logic [31:0] wd, input logic [2:0] f3,
                            input int exp_stall);
        int st;
        issue(1'b0, 1'b1, a, wd, f3, st);
        chk("store_stall", 32'(st), 32'(exp_stall));
    endtask

    task automatic do_load(input logic [8:0] a, input logic [2:0] f3, input logic [31:0] exp_data);
        int st;
        exp_t e;
        e.is_err = 1'b0;
        e.data   = exp_data;
        exp_q.push_back(e);
        issue(1'b1, 1'b0, a, 32'h0, f3, st);
        chk("load_stall", 32'(st), 32'd1);
        // Second edge after acceptance presents rd_valid
        chk("load_latency", 32'(rd_valid), 32'd1);
    endtask

    task automatic do_bad(input logic mr, input logic mw, input logic [8:0] a, input logic [2:0] f3);
        int st;
        exp_t e;
        e.is_err = 1'b1;
        e.data   = 32'h0;
        exp_q.push_back(e);
        issue(mr, mw, a, 32'hFFFF_FFFF, f3, st);
        chk("illegal_stall", 32'(st), 32'd0);
        chk("illegal_ready", 32'(req_ready), 32'd1);
    endtask

    initial begin
        int st;
        reset     = 1'b0;
        req_valid = 1'b0;
        MemRead   = 1'b0;
        MemWrite  = 1'b0;
        addr      = '0;
        wr_data   = '0;
        func3     = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready", 32'(req_ready), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_rd_valid", 32'(rd_valid), 32'd0);
        chk("rst_rd_data", rd_data, 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        reset = 1'b1;
        @(posedge clk);
        #1;

        // Word store then back-to-back load of the same word
        do_store(9'h010, 32'hDEADBEEF, 3'b010, 0);
        do_load (9'h010, 3'b010, 32'hDEADBEEF);

        // Byte RMW into lane 1
        do_store(9'h011, 32'h000000A5, 3'b000, 2);
        do_load (9'h011, 3'b100, 32'h000000A5);
        do_load (9'h011, 3'b000, 32'hFFFFFFA5);
        do_load (9'h010, 3'b010, 32'hDEADA5EF);
        do_load (9'h010, 3'b000, 32'hFFFFFFEF);
        do_load (9'h010, 3'b001, 32'hFFFFA5EF);

        // Half RMW into the upper half
        do_store(9'h020, 32'h12345678, 3'b010, 0);
        do_store(9'h022, 32'h00008001, 3'b001, 2);
        do_load (9'h022, 3'b001, 32'hFFFF8001);
        do_load (9'h022, 3'b101, 32'h00008001);
        do_load (9'h020, 3'b010, 32'h80015678);
        do_load (9'h020, 3'b000, 32'h00000078);

        // Illegal requests
        do_bad(1'b1, 1'b0, 9'h013, 3'b010);
        do_bad(1'b0, 1'b1, 9'h021, 3'b001);
        do_bad(1'b1, 1'b0, 9'h010, 3'b011);
        do_bad(1'b1, 1'b1, 9'h010, 3'b010);
        do_bad(1'b0, 1'b1, 9'h010, 3'b100);
        do_load(9'h010, 3'b010, 32'hDEADA5EF);
        do_load(9'h020, 3'b010, 32'h80015678);

        // No-op request
        issue(1'b0, 1'b0, 9'h010, 32'h0, 3'b010, st);
        chk("noop_stall", 32'(st), 32'd0);

        // Reset during RMW_RD aborts the pending write
        do_store(9'h030, 32'h11223344, 3'b010, 0);
        req_valid = 1'b1;
        MemWrite  = 1'b1;
        addr      = 9'h030;
        wr_data   = 32'h000000FF;
        func3     = 3'b000;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        MemWrite  = 1'b0;
        chk("rmw_busy", 32'(busy), 32'd1);
        reset = 1'b0;
        #1;
        chk("abort_ready", 32'(req_ready), 32'd1);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_rd_valid", 32'(rd_valid), 32'd0);
        chk("abort_rd_data", rd_data, 32'd0);
        chk("abort_err", 32'(err), 32'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;

        // 3 loads, 2 SW, 1 SB after reset
        do_store(9'h040, 32'h11111111, 3'b010, 0);
        do_store(9'h044, 32'h22222222, 3'b010, 0);
        do_store(9'h040, 32'h000000AB, 3'b000, 2);
        do_load (9'h030, 3'b010, 32'h11223344);
        do_load (9'h040, 3'b010, 32'h111111AB);
        do_load (9'h044, 3'b010, 32'h22222222);
`ifdef DMEM_PERF_EN
        chk("load_cnt", 32'(load_cnt), 32'd3);
        chk("store_cnt", 32'(store_cnt), 32'd3);
        chk("stall_cnt", 32'(stall_cnt), 32'd5);
`endif

        repeat (4) @(posedge clk);
        #1;
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation still running at %0t, limit 200000", $time);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/dmem_ctrl.md
Name: dmem_ctrl

Overview:
Data-memory controller that sits directly downstream of the pipeline's EX/MEM register and serves its load and store requests. It owns a word-organised synchronous RAM and implements byte, half and word accesses selected by func3. Sub-word stores use a read-modify-write sequence. It applies a ready/valid handshake, so the pipeline stalls while a multi-cycle access is in flight. It returns sign- or zero-extended load data to the MEM/WB register.

Parameters:
DM_ADDRESS, 9, byte address width
DATA_W, 32, data width; fixed at 32
DEPTH_W, 128, number of 32-bit words; equals 2^(DM_ADDRESS-2)

Ports:
clk  input  1  clock; all state updates on its rising edge
reset  input  1  asynchronous, active-low reset
req_valid  input  1  request present
req_ready  output  1  controller can accept a request; high only in IDLE
MemRead  input  1  load request
MemWrite  input  1  store request
addr  input  DM_ADDRESS  byte address
wr_data  input  DATA_W  store data, right-aligned
func3  input  3  access size and sign
rd_valid  output  1  one-cycle pulse; rd_data is valid
rd_data  output  DATA_W  extended load data; holds its value until the next rd_valid
err  output  1  one-cycle pulse on an illegal request
busy  output  1  equals !req_ready; used as the pipeline stall

Behaviour:
- Reset (reset=0) forces:
  - state=IDLE, req_ready=1, busy=0
  - rd_valid=0, rd_data=0, err=0
  - RAM contents are not cleared.
- A request is accepted on a clock edge where req_valid && req_ready.
- Request fields are registered at acceptance; inputs are ignored while busy.
- Word index = addr[DM_ADDRESS-1:2]; byte lane = addr[1:0].
- func3 encoding:
  - Loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
  - Stores: 000 SB, 001 SH, 010 SW.
- Illegal request conditions:
  - MemRead && MemWrite both set.
  - Load func3 in {011, 110, 111}.
  - Store func3 not in {000, 001, 010}.
  - Half access with addr[0]=1.
  - Word access with addr[1:0]!=0.
- Illegal request handling:
  - Accepted, then err=1 for the cycle after acceptance.
  - No RAM write, rd_valid stays 0, stays in IDLE.
- A valid request with neither MemRead nor MemWrite is accepted as a no-op.
- FSM states: IDLE, LOAD, RMW_RD, RMW_WR.
- IDLE transitions:
  - Legal SW: RAM written at the acceptance edge; stay in IDLE. Zero-stall store, 1-cycle occupancy.
  - Legal load: go to LOAD; RAM read is issued.
  - Legal SB/SH: go to RMW_RD.
- LOAD:
  - Next edge captures the word, extends per func3 into rd_data and pulses rd_valid=1, then returns to IDLE.
  - Load latency is 2 edges from acceptance to rd_valid; req_ready is low for 1 cycle.
- RMW_RD:
  - Reads the target word.
  - Next edge goes to RMW_WR.
- RMW_WR:
  - Merges the byte/half from wr_data[7:0] or [15:0] into the selected lane(s).
  - Writes the merged word and returns to IDLE.
  - req_ready is low for 2 cycles.
- Extension: LB/LH sign-extend from bit 7/15; LBU/LHU zero-extend; LW passes the word unchanged.
- Back-to-back:
  - A request presented in the cycle req_ready returns high is accepted that edge.
  - A load immediately following a store to the same word returns the new data (write precedes the read in RAM order).
- Reset asserted mid-operation:
  - Aborts immediately; no pending RMW write occurs.
  - rd_valid is not issued.
- Address wrap: none. addr is fully decoded and all words are reachable.

Optional Feature:
DMEM_PERF_EN:
- When defined, adds three outputs, each 16 bits, saturating at 16'hFFFF and cleared by reset:
  - load_cnt: incremented per legal load accepted.
  - store_cnt: incremented per legal store accepted.
  - stall_cnt: incremented each cycle busy=1.
- When undefined, these ports and counters do not exist and the behaviour above is unchanged.

Test Plan:
- SW addr=0x010 data=0xDEADBEEF, then LW addr=0x010 -> no stall on the store; rd_valid 2 edges after load acceptance; rd_data=0xDEADBEEF.
- After the above, SB addr=0x011 data=0x000000A5, then LBU 0x011 and LB 0x011 -> busy high 2 cycles on the SB; word=0xDEADA5EF; LBU returns 0x000000A5; LB returns 0xFFFFFFA5.
- SH addr=0x022 data=0x00008001, then LH 0x022 and LHU 0x022 -> LH returns 0xFFFF8001; LHU returns 0x00008001; lower half of word 0x020 unchanged.
- LW addr=0x013, SH addr=0x021, and func3=011 load -> err pulses 1 cycle each; rd_valid never asserts; memory unchanged; req_ready stays 1.
- Start SB to 0x030 (word preloaded 0x11223344), assert reset low during RMW_RD -> outputs return to reset values; word 0x030 still reads 0x11223344.
- With DMEM_PERF_EN defined: 3 loads, 2 SW, 1 SB -> load_cnt=3, store_cnt=3, stall_cnt=5 (3×1 + 1×2).
